irq_controller: RTL and testbench

Interrupt request front end that drives the 8-bit `interrupt_source` vector consumed by the coprocessor-0 unit. It latches device requests per line as edge- or level-triggered, applies a per-line enable mask, and owns a MIPS-style Count/Compare timer hard-wired to line 7. Software accesses it through a small register window (read/write by register number) to acknowledge, mask, configure and program the timer.

---
 rtl/irq_controller.sv | 108 ++++++++++
 tb/tb_irq_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Interrupt front end: per-line edge/level latching, enable mask, and a
// Count/Compare timer on the top line, all behind a small register window.
module irq_controller #(
  parameter int NUM_EXT = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_EXT-1:0] irq_in,
  input  logic [2:0]         regnum,
  input  logic [63:0]        wr_data,
  input  logic               wr_enable,
  output logic [63:0]        rd_data,
  output logic [NUM_EXT:0]   interrupt_source
);

  localparam int TIMER = NUM_EXT;

  logic [NUM_EXT:0]   pending;
  logic [NUM_EXT:0]   mask;
  logic [NUM_EXT-1:0] edge_sel;
  logic [NUM_EXT-1:0] prev;
  logic [31:0]        count;
  logic [31:0]        compare;

  logic [NUM_EXT:0]   next_pending;
  logic [NUM_EXT:0]   next_mask;
  logic [NUM_EXT:0]   w1c;
  logic [NUM_EXT-1:0] rise;
  logic [NUM_EXT:0]   masked;
  logic [3:0]         highest;
  logic               hit;
  logic               wr_pend, wr_mask, wr_edge, wr_count, wr_cmp;
  logic               unused_wr_high;

  assign unused_wr_high = ^wr_data[63:32];

  assign wr_pend  = wr_enable && (regnum == 3'd0);
  assign wr_mask  = wr_enable && (regnum == 3'd1);
  assign wr_edge  = wr_enable && (regnum == 3'd2);
  assign wr_count = wr_enable && (regnum == 3'd3);
  assign wr_cmp   = wr_enable && (regnum == 3'd4);

  assign w1c    = wr_pend ? wr_data[NUM_EXT:0] : '0;
  assign rise   = irq_in & ~prev;
  assign hit    = (count == compare);
  assign masked = pending & mask;

  // A new request always beats a simultaneous clear, for both device and timer lines.
  always_comb begin
    next_pending = pending;
    for (int i = 0; i < NUM_EXT; i++) begin
      if (edge_sel[i])
        next_pending[i] = rise[i] | (pending[i] & ~w1c[i]);
      else
        next_pending[i] = irq_in[i];
    end
    next_pending[TIMER] = hit | (pending[TIMER] & ~(w1c[TIMER] | wr_cmp));
    next_mask = wr_mask ? wr_data[NUM_EXT:0] : mask;
  end

  always_comb begin
    highest = 4'd0;
    for (int i = 0; i <= NUM_EXT; i++) begin
      if (masked[i])
        highest = {1'b1, i[2:0]};
    end
  end

  always_comb begin
    rd_data = 64'd0;
    case (regnum)
      3'd0:    rd_data = 64'(pending);
      3'd1:    rd_data = 64'(mask);
      3'd2:    rd_data = 64'({1'b1, edge_sel});
      3'd3:    rd_data = 64'(count);
      3'd4:    rd_data = 64'(compare);
      3'd5:    rd_data = 64'(highest);
      default: rd_data = 64'd0;
    endcase
  end

  // interrupt_source is registered from next-state values so it needs no output gating.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending          <= '0;
      mask             <= '1;
      edge_sel         <= '0;
      prev             <= '0;
      count            <= 32'd0;
      compare          <= 32'hFFFF_FFFF;
      interrupt_source <= '0;
    end else begin
      pending          <= next_pending;
      mask             <= next_mask;
      prev             <= irq_in;
      interrupt_source <= next_pending & next_mask;
      if (wr_edge)
        edge_sel <= wr_data[NUM_EXT-1:0];
      if (wr_count)
        count <= wr_data[31:0];
      else
        count <= count + 32'd1;
      if (wr_cmp)
        compare <= wr_data[31:0];
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: a per-cycle behavioural model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_irq_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  irq_in = '0;
  logic [2:0]  regnum = '0;
  logic [63:0] wr_data = '0;
  logic        wr_enable = 1'b0;
  logic [63:0] rd_data;
  logic [7:0]  interrupt_source;

  int total = 0;
  int bad = 0;

  irq_controller #(.NUM_EXT(7)) dut (
    .clock(clock),
    .reset(reset),
    .irq_in(irq_in),
    .regnum(regnum),
    .wr_data(wr_data),
    .wr_enable(wr_enable),
    .rd_data(rd_data),
    .interrupt_source(interrupt_source)
  );

  always #5 clock = ~clock;

  // Behavioural model of the software-visible state
  bit [7:0]        m_pend, m_mask, m_src, np;
  bit [6:0]        m_edge, m_prev;
  longint unsigned m_count, m_cmp;
  bit              wp;

  always @(posedge clock) begin
    if (reset) begin
      m_pend = 0; m_mask = 8'hFF; m_edge = 0; m_prev = 0;
      m_count = 0; m_cmp = 64'hFFFF_FFFF; m_src = 0;
    end else begin
      wp = wr_enable && regnum == 3'd0;
      for (int i = 0; i < 7; i++) begin
        if (m_edge[i]) begin
          if (irq_in[i] && !m_prev[i]) np[i] = 1'b1;
          else if (wp && wr_data[i]) np[i] = 1'b0;
          else np[i] = m_pend[i];
        end else
          np[i] = irq_in[i];
      end
      if (m_count == m_cmp) np[7] = 1'b1;
      else if ((wp && wr_data[7]) || (wr_enable && regnum == 3'd4)) np[7] = 1'b0;
      else np[7] = m_pend[7];
      if (wr_enable && regnum == 3'd3) m_count = longint'(wr_data[31:0]);
      else m_count = (m_count + 1) % 64'h1_0000_0000;
      if (wr_enable && regnum == 3'd4) m_cmp = longint'(wr_data[31:0]);
      if (wr_enable && regnum == 3'd1) m_mask = wr_data[7:0];
      if (wr_enable && regnum == 3'd2) m_edge = wr_data[6:0];
      m_prev = irq_in;
      m_pend = np;
      m_src  = m_pend & m_mask;
    end
  end

  function automatic logic [63:0] model_read(input logic [2:0] r);
    logic [63:0] v;
    bit [7:0] act;
    v = 0;
    act = m_pend & m_mask;
    case (r)
      3'd0: v = 64'(m_pend);
      3'd1: v = 64'(m_mask);
      3'd2: v = 64'({1'b1, m_edge});
      3'd3: v = m_count;
      3'd4: v = m_cmp;
      3'd5: for (int i = 0; i < 8; i++) if (act[i]) v = 64'(8 + i);
      default: v = 0;
    endcase
    return v;
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      total++;
      if (interrupt_source !== m_src) begin
        bad++;
        $display("[TB] FAIL model_src: got %h expected %h", interrupt_source, m_src);
      end
      total++;
      if (rd_data !== model_read(regnum)) begin
        bad++;
        $display("[TB] FAIL model_rd reg%0d: got %h expected %h", regnum, rd_data, model_read(regnum));
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [31:0] d);
    regnum = r;
    wr_data = {32'hDEAD_BEEF, d};
    wr_enable = 1'b1;
    step();
    wr_enable = 1'b0;
  endtask

  task automatic readReg(input string name, input logic [2:0] r, input logic [63:0] exp);
    regnum = r;
    #1;
    checkOutput(name, rd_data, exp);
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b0;

    checkOutput("reset_src", 64'(interrupt_source), 64'h00);
    readReg("reset_mask", 3'd1, 64'hFF);
    readReg("reset_edge", 3'd2, 64'h80);
    readReg("reset_cmp", 3'd4, 64'hFFFF_FFFF);
    readReg("count0", 3'd3, 64'd0);
    step();
    readReg("count1", 3'd3, 64'd1);
    step();
    readReg("count2", 3'd3, 64'd2);

    // Edge-triggered line 0 with W1C
    applyStimulus(3'd2, 32'h01);
    irq_in = 7'h01;
    step();
    irq_in = 7'h00;
    checkOutput("edge_set", 64'(interrupt_source), 64'h01);
    step();
    checkOutput("edge_hold", 64'(interrupt_source), 64'h01);
    applyStimulus(3'd0, 32'h01);
    checkOutput("edge_w1c", 64'(interrupt_source), 64'h00);
    irq_in = 7'h01;
    applyStimulus(3'd0, 32'h01);
    irq_in = 7'h00;
    checkOutput("edge_set_wins", 64'(interrupt_source), 64'h01);

    // Level-triggered line 3
    applyStimulus(3'd2, 32'h00);
    step();
    irq_in = 7'h08;
    step();
    checkOutput("level_set", 64'(interrupt_source), 64'h08);
    applyStimulus(3'd0, 32'h08);
    checkOutput("level_w1c_noop", 64'(interrupt_source), 64'h08);
    irq_in = 7'h00;
    step();
    checkOutput("level_drop", 64'(interrupt_source), 64'h00);

    // Mask and priority
    applyStimulus(3'd2, 32'h7F);
    irq_in = 7'h22;
    step();
    irq_in = 7'h00;
    applyStimulus(3'd1, 32'h02);
    checkOutput("mask_src", 64'(interrupt_source), 64'h02);
    readReg("highest_masked", 3'd5, 64'h9);
    readReg("pending_unmasked", 3'd0, 64'h22);
    applyStimulus(3'd1, 32'hFF);
    readReg("highest_full", 3'd5, 64'hD);
    applyStimulus(3'd0, 32'h22);
    checkOutput("mask_clear", 64'(interrupt_source), 64'h00);

    // Timer
    applyStimulus(3'd3, 32'd10);
    applyStimulus(3'd4, 32'd15);
    regnum = 3'd3;
    #1;
    for (int n = 0; n < 40 && rd_data[31:0] != 32'd15; n++) step();
    checkOutput("timer_reach15", rd_data, 64'd15);
    checkOutput("timer_before_hit", 64'(interrupt_source), 64'h00);
    step();
    checkOutput("timer_hit", 64'(interrupt_source), 64'h80);
    applyStimulus(3'd4, 32'd100);
    checkOutput("timer_cmp_clear", 64'(interrupt_source), 64'h00);
    applyStimulus(3'd3, 32'hFFFF_FFFF);
    readReg("count_max", 3'd3, 64'hFFFF_FFFF);
    step();
    readReg("count_wrap", 3'd3, 64'd0);

    // Build pending = 0xFF, then reset together with a W1C write
    applyStimulus(3'd4, 32'd200);
    irq_in = 7'h7F;
    applyStimulus(3'd3, 32'd200);
    irq_in = 7'h00;
    step();
    readReg("pending_all", 3'd0, 64'hFF);
    regnum = 3'd0;
    wr_data = 64'hFF;
    wr_enable = 1'b1;
    reset = 1'b1;
    irq_in = 7'h7F;
    step();
    wr_enable = 1'b0;
    reset = 1'b0;
    irq_in = 7'h00;
    checkOutput("rst_src", 64'(interrupt_source), 64'h00);
    readReg("rst_pending", 3'd0, 64'h00);
    readReg("rst_mask", 3'd1, 64'hFF);
    readReg("rst_edge", 3'd2, 64'h80);
    readReg("rst_count", 3'd3, 64'd0);
    readReg("rst_cmp", 3'd4, 64'hFFFF_FFFF);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
